// File: rtl/exu_wb_arbiter.sv
// Execute-unit completion and writeback stage.
// Each functional unit pushes results into its own small FIFO. One non-empty
// FIFO head is granted per cycle, either by fixed priority or by round-robin.
// The granted entry drives a registered register-file write port and a
// retire pulse. A counter tracks dispatched-but-unretired instructions so
// that decode can stall.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   dispatch_vld       decode dispatches one instruction
//   issue_rdy          outstanding count below MAX_OUTSTANDING
//   flush              drop buffered results, clear outstanding count
//   fu_res_*           per-unit result channels (valid, dst_vld, addr, data)
//   fu_res_rdy         per-unit FIFO not full
//   wb_vld/addr/data   registered register-file write port
//   retire             one-cycle pulse per popped result
//   err_ovf, err_unf   sticky overflow / outstanding-underflow flags
module exu_wb_arbiter #(
  parameter int unsigned NUM_FU          = 4,
  parameter int unsigned XLEN            = 64,
  parameter int unsigned REG_ADDR_WIDTH  = 5,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RR_MODE         = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             dispatch_vld,
  output logic                             issue_rdy,
  input  logic                             flush,
  input  logic [NUM_FU-1:0]                fu_res_vld,
  input  logic [NUM_FU-1:0]                fu_res_dst_vld,
  input  logic [NUM_FU*REG_ADDR_WIDTH-1:0] fu_res_addr,
  input  logic [NUM_FU*XLEN-1:0]           fu_res_data,
  output logic [NUM_FU-1:0]                fu_res_rdy,
  output logic                             wb_vld,
  output logic [REG_ADDR_WIDTH-1:0]        wb_addr,
  output logic [XLEN-1:0]                  wb_data,
  output logic                             retire,
  output logic                             err_ovf,
  output logic                             err_unf
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned IDX_W  = $clog2(NUM_FU);
  localparam int unsigned CAND_W = IDX_W + 1;
  localparam int unsigned OUT_W  = 4;
  localparam int unsigned ENT_W  = 1 + REG_ADDR_WIDTH + XLEN;

  logic [ENT_W-1:0]  mem    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_FU];
  logic [PTR_W-1:0]  rd_ptr [NUM_FU];
  logic [CNT_W-1:0]  cnt    [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr;
  logic [OUT_W-1:0]  outstanding;

  logic [NUM_FU-1:0] not_empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop_oh;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_vld;
  logic [CAND_W-1:0] cand;
  logic              pop;
  logic              dispatch_ok;
  logic [ENT_W-1:0]  head;
  logic              head_dst_vld;
  logic [REG_ADDR_WIDTH-1:0] head_addr;
  logic [XLEN-1:0]   head_data;
  logic              head_writes;

  // FIFO status; readiness looks at occupancy only, never at a same-cycle pop
  always_comb begin
    not_empty  = '0;
    fu_res_rdy = '0;
    push       = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      not_empty[i]  = (cnt[i] != '0);
      fu_res_rdy[i] = (cnt[i] < CNT_W'(FIFO_DEPTH));
      push[i]       = fu_res_vld[i] & fu_res_rdy[i] & ~flush;
    end
  end

  // Grant search: from index 0 (fixed) or from rr_ptr with wrap (round-robin)
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      cand = (RR_MODE != 0) ? (CAND_W'(rr_ptr) + CAND_W'(k)) : CAND_W'(k);
      if (cand >= CAND_W'(NUM_FU)) cand = cand - CAND_W'(NUM_FU);
      if (!grant_vld && not_empty[cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  // A flush cancels the pop of its cycle
  always_comb begin
    pop    = grant_vld & ~flush;
    pop_oh = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      pop_oh[i] = pop && (grant_idx == IDX_W'(i));
    end
  end

  assign head         = mem[grant_idx][rd_ptr[grant_idx]];
  assign head_dst_vld = head[ENT_W-1];
  assign head_addr    = head[XLEN +: REG_ADDR_WIDTH];
  assign head_data    = head[XLEN-1:0];
  // x0 is hard-wired zero, so writes to it are suppressed
  assign head_writes  = head_dst_vld && (head_addr != '0);

  assign issue_rdy   = (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign dispatch_ok = dispatch_vld & issue_rdy & ~flush;

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {fu_res_dst_vld[i],
                              fu_res_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                              fu_res_data[i*XLEN +: XLEN]};
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (!rst_n || flush) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end else begin
        if (push[i])   wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_oh[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop_oh[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Writeback port, retire pulse, arbitration pointer, outstanding count, errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_vld      <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      retire      <= 1'b0;
      rr_ptr      <= '0;
      outstanding <= '0;
      err_ovf     <= 1'b0;
      err_unf     <= 1'b0;
    end else begin
      retire <= pop;
      wb_vld <= pop & head_writes;
      if (pop && head_writes) begin
        wb_addr <= head_addr;
        wb_data <= head_data;
      end
      if (pop) begin
        rr_ptr <= (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      if ((fu_res_vld & ~fu_res_rdy) != '0) err_ovf <= 1'b1;
      if (pop && (outstanding == '0))      err_unf <= 1'b1;
      if (flush) begin
        outstanding <= '0;
      end else begin
        case ({dispatch_ok, pop})
          2'b10:   outstanding <= outstanding + OUT_W'(1);
          2'b01:   if (outstanding != '0) outstanding <= outstanding - OUT_W'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Bench for exu_wb_arbiter: a round-robin instance (index 0) and a
// fixed-priority instance (index 1) share the same stimulus. A queue-level
// model predicts both, compared every cycle, plus directed literal checks.
module tb_exu_wb_arbiter;

  localparam int NF    = 4;
  localparam int XL    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int MAXO  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, dispatch_vld, flush;
  logic [NF-1:0]      vld, dv;
  logic [NF*AW-1:0]   addr;
  logic [NF*XL-1:0]   data;

  logic [1:0]              issue_rdy_o, wb_vld_o, retire_o, ovf_o, unf_o;
  logic [1:0][NF-1:0]      rdy_o;
  logic [1:0][AW-1:0]      wba_o;
  logic [1:0][XL-1:0]      wbd_o;

  exu_wb_arbiter #(.NUM_FU(NF), .XLEN(XL), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
                   .MAX_OUTSTANDING(MAXO), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .dispatch_vld(dispatch_vld), .issue_rdy(issue_rdy_o[0]),
    .flush(flush), .fu_res_vld(vld), .fu_res_dst_vld(dv), .fu_res_addr(addr),
    .fu_res_data(data), .fu_res_rdy(rdy_o[0]), .wb_vld(wb_vld_o[0]), .wb_addr(wba_o[0]),
    .wb_data(wbd_o[0]), .retire(retire_o[0]), .err_ovf(ovf_o[0]), .err_unf(unf_o[0]));

  exu_wb_arbiter #(.NUM_FU(NF), .XLEN(XL), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
                   .MAX_OUTSTANDING(MAXO), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .dispatch_vld(dispatch_vld), .issue_rdy(issue_rdy_o[1]),
    .flush(flush), .fu_res_vld(vld), .fu_res_dst_vld(dv), .fu_res_addr(addr),
    .fu_res_data(data), .fu_res_rdy(rdy_o[1]), .wb_vld(wb_vld_o[1]), .wb_addr(wba_o[1]),
    .wb_data(wbd_o[1]), .retire(retire_o[1]), .err_ovf(ovf_o[1]), .err_unf(unf_o[1]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int m, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t: got %0h, expected %0h", nm, m, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          dv;
    logic [AW-1:0] a;
    logic [XL-1:0] d;
  } ent_t;

  ent_t          mq   [2][NF][DEPTH];
  int            msz  [2][NF];
  int            mout [2];
  int            mptr [2];
  bit            movf [2];
  bit            munf [2];
  bit            ewbv [2];
  bit            eret [2];
  logic [AW-1:0] ewba [2];
  logic [XL-1:0] ewbd [2];
  bit            model_ok = 1'b0;

  task automatic model_step(input int m, input bit rr);
    int   win;
    int   inc;
    int   dec;
    bit   full [NF];
    ent_t h;
    if (!rst_n) begin
      for (int i = 0; i < NF; i++) msz[m][i] = 0;
      mout[m] = 0; mptr[m] = 0; movf[m] = 0; munf[m] = 0;
      ewbv[m] = 0; eret[m] = 0; ewba[m] = '0; ewbd[m] = '0;
      return;
    end
    for (int i = 0; i < NF; i++) full[i] = (msz[m][i] >= DEPTH);
    inc = (dispatch_vld && mout[m] < MAXO && !flush) ? 1 : 0;
    win = -1;
    if (!flush) begin
      for (int k = 0; k < NF; k++) begin
        int i;
        i = rr ? (mptr[m] + k) % NF : k;
        if (win < 0 && msz[m][i] > 0) win = i;
      end
    end
    dec     = (win >= 0) ? 1 : 0;
    eret[m] = (win >= 0);
    ewbv[m] = 1'b0;
    if (win >= 0) begin
      h = mq[m][win][0];
      for (int j = 0; j < DEPTH - 1; j++) mq[m][win][j] = mq[m][win][j+1];
      msz[m][win]--;
      if (h.dv && h.a != '0) begin
        ewbv[m] = 1'b1; ewba[m] = h.a; ewbd[m] = h.d;
      end
      mptr[m] = (win + 1) % NF;
      if (mout[m] == 0) munf[m] = 1'b1;
    end
    for (int i = 0; i < NF; i++) begin
      if (vld[i]) begin
        if (full[i]) movf[m] = 1'b1;
        else if (!flush) begin
          mq[m][i][msz[m][i]] = '{dv: dv[i], a: addr[i*AW +: AW], d: data[i*XL +: XL]};
          msz[m][i]++;
        end
      end
    end
    mout[m] = mout[m] + inc - dec;
    if (mout[m] < 0) mout[m] = 0;
    if (flush) begin
      for (int i = 0; i < NF; i++) msz[m][i] = 0;
      mout[m] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    if (!rst_n) model_ok = 1'b1;
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      for (int m = 0; m < 2; m++) begin
        logic [NF-1:0] er;
        for (int i = 0; i < NF; i++) er[i] = (msz[m][i] < DEPTH);
        check("m_wb_vld",    m, 64'(wb_vld_o[m]),    64'(ewbv[m]));
        check("m_wb_addr",   m, 64'(wba_o[m]),       64'(ewba[m]));
        check("m_wb_data",   m, wbd_o[m],            ewbd[m]);
        check("m_retire",    m, 64'(retire_o[m]),    64'(eret[m]));
        check("m_err_ovf",   m, 64'(ovf_o[m]),       64'(movf[m]));
        check("m_err_unf",   m, 64'(unf_o[m]),       64'(munf[m]));
        check("m_issue_rdy", m, 64'(issue_rdy_o[m]), 64'(mout[m] < MAXO));
        check("m_res_rdy",   m, 64'(rdy_o[m]),       64'(er));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    vld = '0; dv = '0; addr = '0; data = '0; dispatch_vld = 1'b0; flush = 1'b0;
  endtask

  task automatic set_res(input int i, input bit d_v, input logic [AW-1:0] a,
                         input logic [XL-1:0] d);
    vld[i] = 1'b1; dv[i] = d_v; addr[i*AW +: AW] = a; data[i*XL +: XL] = d;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_n = 1'b0;
    step();
    for (int m = 0; m < 2; m++) begin
      check("rst_wb_vld",    m, 64'(wb_vld_o[m]),    64'd0);
      check("rst_retire",    m, 64'(retire_o[m]),    64'd0);
      check("rst_issue_rdy", m, 64'(issue_rdy_o[m]), 64'd1);
      check("rst_res_rdy",   m, 64'(rdy_o[m]),       64'hf);
    end
    rst_n = 1'b1;
    step();

    // 1: single ALU result, latency 2
    dispatch_vld = 1'b1; step(); dispatch_vld = 1'b0;
    set_res(0, 1'b1, 5'd5, 64'hDEAD); step(); clr();
    for (int m = 0; m < 2; m++) check("t1_retire_early", m, 64'(retire_o[m]), 64'd0);
    step();
    for (int m = 0; m < 2; m++) begin
      check("t1_wb_vld",  m, 64'(wb_vld_o[m]), 64'd1);
      check("t1_wb_addr", m, 64'(wba_o[m]),    64'd5);
      check("t1_wb_data", m, wbd_o[m],         64'hDEAD);
      check("t1_retire",  m, 64'(retire_o[m]), 64'd1);
    end
    step();
    for (int m = 0; m < 2; m++) begin
      check("t1_retire_off", m, 64'(retire_o[m]),    64'd0);
      check("t1_issue_rdy",  m, 64'(issue_rdy_o[m]), 64'd1);
      check("t1_err_unf",    m, 64'(unf_o[m]),       64'd0);
    end

    // 2: simultaneous burst, order 0..3 then wrap back to unit 0
    do_reset();
    for (int i = 0; i < NF; i++) set_res(i, 1'b1, AW'(i + 1), 64'h100 + 64'(i));
    step(); clr();
    for (int k = 0; k < NF; k++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        check("t2_retire", m, 64'(retire_o[m]), 64'd1);
        check("t2_order",  m, 64'(wba_o[m]),    64'(k + 1));
      end
    end
    for (int i = 0; i < NF; i++) set_res(i, 1'b1, AW'(i + 11), 64'h200 + 64'(i));
    step(); clr(); step();
    check("t2_wrap", 0, 64'(wba_o[0]), 64'd11);
    repeat (4) step();

    // 2b: unit 0 refilled every cycle starves unit 1 under fixed priority
    do_reset();
    set_res(0, 1'b1, 5'd1, 64'hA0); set_res(1, 1'b1, 5'd2, 64'hB0); step();
    for (int k = 1; k <= 4; k++) begin
      clr(); set_res(0, 1'b1, 5'd1, 64'hA0 + 64'(k)); step();
      check("t2_starve", 1, 64'(wba_o[1]), 64'd1);
    end
    clr(); step(); step();
    check("t2_unstarve", 1, 64'(wba_o[1]), 64'd2);
    repeat (4) step();

    // 3: store (no dst) then write to x0: retire without writeback
    do_reset();
    set_res(1, 1'b0, 5'd7, 64'h11); step(); clr();
    set_res(1, 1'b1, 5'd0, 64'h22); step(); clr();
    for (int m = 0; m < 2; m++) begin
      check("t3_retire_a", m, 64'(retire_o[m]), 64'd1);
      check("t3_wbv_a",    m, 64'(wb_vld_o[m]), 64'd0);
    end
    step();
    for (int m = 0; m < 2; m++) begin
      check("t3_retire_b", m, 64'(retire_o[m]), 64'd1);
      check("t3_wbv_b",    m, 64'(wb_vld_o[m]), 64'd0);
      check("t3_wbd_hold", m, wbd_o[m],         64'd0);
    end
    step();

    // 4: unit 2 overflows while unit 0 keeps winning fixed priority
    do_reset();
    for (int k = 0; k < 4; k++) begin
      clr();
      set_res(0, 1'b1, 5'd3, 64'(k));
      if (k < 3) set_res(2, 1'b1, 5'd4, 64'h300 + 64'(k));
      step();
      if (k == 0) check("t4_ovf_clear", 1, 64'(ovf_o[1]), 64'd0);
      if (k >= 1) check("t4_rdy2_full", 1, 64'(rdy_o[1][2]), 64'd0);
      if (k == 2) check("t4_ovf_set",   1, 64'(ovf_o[1]), 64'd1);
    end
    clr();
    repeat (5) step();

    // 5: outstanding limit
    do_reset();
    dispatch_vld = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 3) check("t5_rdy_3", 0, 64'(issue_rdy_o[0]), 64'd1);
      if (k >= 4) check("t5_stall", 0, 64'(issue_rdy_o[0]), 64'd0);
    end
    clr();
    set_res(3, 1'b1, 5'd9, 64'h55); step(); clr(); step();
    for (int m = 0; m < 2; m++) begin
      check("t5_retire",  m, 64'(retire_o[m]),    64'd1);
      check("t5_rdy_back", m, 64'(issue_rdy_o[m]), 64'd1);
    end
    for (int i = 0; i < 3; i++) set_res(i, 1'b1, AW'(20 + i), 64'h60 + 64'(i));
    step(); clr(); repeat (3) step();
    for (int m = 0; m < 2; m++) check("t5_no_unf", m, 64'(unf_o[m]), 64'd0);
    set_res(0, 1'b1, 5'd6, 64'h66); step(); clr(); step();
    for (int m = 0; m < 2; m++) check("t5_unf", m, 64'(unf_o[m]), 64'd1);

    // 6: flush with buffered entries and a colliding push, then mid-stream reset
    do_reset();
    for (int i = 0; i < 3; i++) set_res(i, 1'b1, AW'(i + 1), 64'h70 + 64'(i));
    step(); clr();
    flush = 1'b1; dispatch_vld = 1'b1; set_res(3, 1'b1, 5'd8, 64'h88);
    step(); clr();
    for (int m = 0; m < 2; m++) begin
      check("t6_retire",    m, 64'(retire_o[m]),    64'd0);
      check("t6_wb_vld",    m, 64'(wb_vld_o[m]),    64'd0);
      check("t6_issue_rdy", m, 64'(issue_rdy_o[m]), 64'd1);
      check("t6_res_rdy",   m, 64'(rdy_o[m]),       64'hf);
    end
    repeat (2) begin
      step();
      for (int m = 0; m < 2; m++) check("t6_quiet", m, 64'(retire_o[m]), 64'd0);
    end
    dispatch_vld = 1'b1;
    for (int i = 0; i < NF; i++) set_res(i, 1'b1, AW'(i + 12), 64'h90 + 64'(i));
    step(); clr(); step();
    rst_n = 1'b0;
    set_res(1, 1'b1, 5'd3, 64'h99);
    step(); clr();
    for (int m = 0; m < 2; m++) begin
      check("t6r_wb_vld",  m, 64'(wb_vld_o[m]),    64'd0);
      check("t6r_wb_addr", m, 64'(wba_o[m]),       64'd0);
      check("t6r_wb_data", m, wbd_o[m],            64'd0);
      check("t6r_retire",  m, 64'(retire_o[m]),    64'd0);
      check("t6r_errs",    m, 64'({ovf_o[m], unf_o[m]}), 64'd0);
      check("t6r_rdy",     m, 64'({issue_rdy_o[m], rdy_o[m]}), 64'h1f);
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      for (int m = 0; m < 2; m++) check("t6r_dropped", m, 64'(retire_o[m]), 64'd0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
